// File: rtl/palette_update_ctrl_pkg.sv
// Shared types and constants for the palette update controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package palette_update_ctrl_pkg;

    localparam int COLOR_W     = 84;
    localparam int BIN_COLOR_W = 12;
    localparam int NUM_BINS    = COLOR_W / BIN_COLOR_W;

    // Palette shown until the first FFT-derived colour word is committed.
    localparam logic [COLOR_W-1:0] PAL_DEFAULT_COLOR = 84'hFFF_FF0_F0F_00F_0F0_D08_0FF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        PENDING   = 2'd3
    } pal_state_t;

endpackage

// File: rtl/palette_update_ctrl_sync_fall_detect.sv
// Synchronises an asynchronous active-low strobe and pulses on its falling edge.
// Latency: STAGES cycles from input fall to the one-cycle fall pulse.
// Backpressure: none; the pulse is emitted unconditionally.
module sync_fall_detect #(
    parameter int STAGES = 2              // must be at least 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Synchroniser chain plus one history flop; all idle high after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            hist_q <= sync_q[STAGES-1];
        end
    end

    // One-cycle pulse when the synchronised level goes from high to low.
    assign fall = hist_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/palette_update_ctrl.sv
// Sequences one FFT_energy colour run per audio frame and commits the palette on vsync fall.
// Latency: fft_ready -> start 1 cycle; vsync fall -> commit SYNC_STAGES+1 cycles.
// Backpressure: one extra request is queued while busy; further ones are dropped and counted.
module palette_update_ctrl
    import palette_update_ctrl_pkg::*;
#(
    parameter logic [19:0]        TIMEOUT_CYCLES = 20'd1_000_000,
    parameter int                 SYNC_STAGES    = 2,
    parameter logic [COLOR_W-1:0] DEFAULT_COLOR  = PAL_DEFAULT_COLOR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fft_ready,
    input  logic               fft_done,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               vsync,
    input  logic               freeze,
    output logic               start,
    output logic [COLOR_W-1:0] color_out,
    output logic               commit,
    output logic               busy,
    output logic               timeout_err,
    output logic [7:0]         overrun_cnt
);

    pal_state_t         state_q, state_d;
    logic [COLOR_W-1:0] shadow_q;
    logic [19:0]        cnt_q, cnt_d;
    logic               req_q, req_d;
    logic [7:0]         ovr_d;
    logic               shadow_ld;
    logic               commit_d;
    logic               timeout_set;
    logic               vs_fall;

    sync_fall_detect #(
        .STAGES (SYNC_STAGES)
    ) u_vs_fall (
        .clock    (clock),
        .reset    (reset),
        .async_in (vsync),
        .fall     (vs_fall)
    );

    assign busy = (state_q != IDLE);

    // Next-state, request queue, overrun count and datapath strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        ovr_d       = overrun_cnt;
        start       = 1'b0;
        shadow_ld   = 1'b0;
        commit_d    = 1'b0;
        timeout_set = 1'b0;

        // A request arriving while busy is queued once; any more are lost.
        if (fft_ready && (state_q != IDLE)) begin
            if (!req_q) begin
                req_d = 1'b1;
            end else if (overrun_cnt != 8'hFF) begin
                ovr_d = overrun_cnt + 8'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (fft_ready || req_q) begin
                    state_d = START;
                    req_d   = 1'b0;
                end
            end
            START: begin
                start   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // fft_done takes priority over the terminal count.
                if (fft_done) begin
                    shadow_ld = 1'b1;
                    state_d   = PENDING;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                    if (cnt_d == (TIMEOUT_CYCLES - 20'd1)) begin
                        timeout_set = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            PENDING: begin
                if (vs_fall && !freeze) begin
                    commit_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
            commit      <= 1'b0;
            shadow_q    <= DEFAULT_COLOR;
            color_out   <= DEFAULT_COLOR;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            overrun_cnt <= ovr_d;
            commit      <= commit_d;
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end
            if (shadow_ld) begin
                shadow_q <= color_in;
            end
            if (commit_d) begin
                color_out <= shadow_q;
            end
        end
    end

endmodule

// File: doc/palette_update_ctrl.md
Name: palette_update_ctrl

Overview:
- Sequences one FFT_energy colour computation per audio frame and owns the 84-bit palette that feeds Color_output.
- Receives the FFT-ready pulse from the audio path, issues a start pulse to FFT_energy, and captures its colour word when done.
- Commits the new palette only at a VGA vertical-sync falling edge, so a frame never shows a mix of old and new colours.
- Sits between wubs_done/FFT_energy and Color_output in the colour-transform top level, on the 100 MHz domain.

Parameters:
- TIMEOUT_CYCLES, 1_000_000: max cycles to wait for fft_done after start (10 ms at 100 MHz); width 20 bits.
- SYNC_STAGES, 2: flop stages on the asynchronous vsync input; minimum 2.
- DEFAULT_COLOR, 84'hFFF_FF0_F0F_00F_0F0_D08_0FF: palette loaded on reset.

Ports:
- clock  in  1  100 MHz system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- fft_ready  in  1  one-cycle pulse: a new FFT frame is in BRAM (wubs_done).
- fft_done  in  1  one-cycle pulse from FFT_energy: color_in is valid this cycle.
- color_in  in  84  colour word from FFT_energy, 7 x 12-bit RGB.
- vsync  in  1  VGA vsync from the 25 MHz domain, active low, asynchronous.
- freeze  in  1  level; 1 holds the current palette (commits deferred).
- start  out  1  one-cycle pulse to FFT_energy.
- color_out  out  84  committed palette to Color_output.
- commit  out  1  one-cycle pulse when color_out changes.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; cleared only by reset.
- overrun_cnt  out  8  saturating count of dropped fft_ready pulses.

Behaviour:
- Reset values, applied on the first rising edge with reset=1 and overriding everything, mid-operation included:
  - state=IDLE, start=0, commit=0, busy=0, timeout_err=0, overrun_cnt=0, req_pending=0.
  - color_out=DEFAULT_COLOR, shadow=DEFAULT_COLOR, timeout counter=0.
  - Synchroniser flops are reset to 1 (vsync idle high).
- vsync handling:
  - vsync passes through SYNC_STAGES flops plus one history flop.
  - vs_fall = history & ~synced. It is a one-cycle pulse, combinational from registers.
- States:
  - IDLE: if fft_ready or req_pending, go to START and clear req_pending.
  - START: start=1 for exactly this cycle, counter cleared, go to WAIT_DONE. Latency is fft_ready at cycle t -> start high at t+1.
  - WAIT_DONE:
    - fft_done=1: shadow<=color_in, go to PENDING.
    - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1, set timeout_err, go to IDLE; shadow and color_out are unchanged.
  - PENDING: if vs_fall=1 and freeze=0, color_out<=shadow, commit=1 next cycle, go to IDLE. If freeze=1, stay in PENDING. Later fft_ready pulses are handled by the overrun rule.
- Overrun rule, when fft_ready=1 in any state other than IDLE:
  - req_pending=0: set req_pending.
  - req_pending=1: the request is dropped and overrun_cnt increments, saturating at 255.
- Simultaneous events:
  - fft_ready in the same cycle as the PENDING->IDLE commit: sets req_pending, and IDLE then starts on the following cycle.
  - fft_done and the timeout terminal count in the same cycle: fft_done wins and timeout_err is not set.
  - fft_done outside WAIT_DONE is ignored.
- Widths: counter is 20-bit unsigned, overrun_cnt is 8-bit unsigned. No arithmetic is done on colour data; it is pass-through only.

Decomposition:
- Shared package: state encoding (IDLE, START, WAIT_DONE, PENDING, 2-bit), DEFAULT_COLOR constant, COLOR_W=84, BIN_COLOR_W=12.
- One natural sub-module, sync_fall_detect: parameterised synchroniser plus falling-edge pulse, reused for any cross-domain strobe.

Test Plan:
- Reset, then fft_ready pulse at cycle 10 -> start=1 only at cycle 11, busy=1 from cycle 11; color_out stays 84'hFFF_FF0_F0F_00F_0F0_D08_0FF.
- fft_done with color_in=84'h00F_00C_00A_008_006_004_003, then vsync 1->0 -> commit pulse 3-4 cycles after the vsync edge (SYNC_STAGES=2); color_out equals the new word; state IDLE.
- freeze=1 over two vsync falls, then freeze=0 before the third -> no commit on the first two, commit on the third.
- Three fft_ready pulses during WAIT_DONE -> req_pending set, overrun_cnt=2; after commit a second start is issued automatically.
- No fft_done after start (TIMEOUT_CYCLES=16) -> timeout_err=1 sixteen cycles after start, state IDLE, color_out unchanged, next fft_ready still starts normally.
- Reset asserted in PENDING and in WAIT_DONE -> all outputs return to reset values on the next edge; a late fft_done is ignored.
